// File: rtl/rf_ram_pkg.sv
// Shared types and constants for the register-file RAM arbiter.
// Optional parity storage is enabled with the RF_RAM_PARITY_EN macro.
package rf_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      SW_RD = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned SW_DATA_WIDTH = 64;

   // Width of a counter that must reach max_stall
   function automatic int unsigned stall_cnt_width(input int unsigned max_stall);
      return $clog2(max_stall + 1);
   endfunction

endpackage

// File: rtl/rf_ram_sp.sv
// Single-port synchronous RAM, read-before-write, with a separate output
// register per requester so each side's read data holds while the other
// side uses the port. Macro RF_RAM_PARITY_EN adds one even-parity bit per word.
module rf_ram_sp #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  we,
   input  logic                  load_hw,
   input  logic                  load_sw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
`ifdef RF_RAM_PARITY_EN
   output logic                  hw_perr,
   output logic                  sw_perr,
`endif
   output logic [DATA_WIDTH-1:0] hw_dout,
   output logic [DATA_WIDTH-1:0] sw_dout
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef RF_RAM_PARITY_EN
   localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
   localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif

   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [WORD_WIDTH-1:0] wword;
   logic [WORD_WIDTH-1:0] rword;

`ifdef RF_RAM_PARITY_EN
   assign wword = {^wdata, wdata};
`else
   assign wword = wdata;
`endif
   assign rword = mem[addr];

   // Storage array; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wword;
      end
   end

   // Per-requester read registers capture the pre-write word
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         hw_dout <= '0;
         sw_dout <= '0;
`ifdef RF_RAM_PARITY_EN
         hw_perr <= 1'b0;
         sw_perr <= 1'b0;
`endif
      end else begin
         if (load_hw) begin
            hw_dout <= rword[DATA_WIDTH-1:0];
         end
         if (load_sw) begin
            sw_dout <= rword[DATA_WIDTH-1:0];
         end
`ifdef RF_RAM_PARITY_EN
         hw_perr <= load_hw & (^rword);
         if (load_sw) begin
            sw_perr <= ^rword;
         end
`endif
      end
   end

endmodule

// File: rtl/rf_ram_arbiter.sv
// Register-file RAM shared between the software register bus and a hardware
// port. Hardware has priority; a stall counter forces a software grant after
// MAX_STALL denied cycles and flags hw_busy for that cycle.
// Macro RF_RAM_PARITY_EN adds per-word parity and the parity_error output.
module rf_ram_arbiter
   import rf_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH    = 5,
   parameter int unsigned SW_ADDR_WIDTH = 8,
   parameter int unsigned BASE_ADDR     = 4,
   parameter int unsigned MAX_STALL     = 4
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic [SW_ADDR_WIDTH-4:0] address,
   input  logic                     read_en,
   input  logic                     write_en,
   input  logic [SW_DATA_WIDTH-1:0] write_data,
   output logic [SW_DATA_WIDTH-1:0] read_data,
   output logic                     invalid_address,
   output logic                     access_complete,
   input  logic [ADDR_WIDTH-1:0]    hw_addr,
   input  logic                     hw_ren,
   output logic [DATA_WIDTH-1:0]    hw_rdata,
   input  logic                     hw_wen,
   input  logic [DATA_WIDTH-1:0]    hw_wdata,
`ifdef RF_RAM_PARITY_EN
   output logic                     parity_error,
`endif
   output logic                     hw_busy
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = stall_cnt_width(MAX_STALL);

   state_t                state;
   logic [CW-1:0]         stall_cnt;
   logic [ADDR_WIDTH-1:0] sw_idx;
   logic                  sw_we;
   logic [DATA_WIDTH-1:0] sw_wdata;

   logic [31:0]           addr_w;
   logic                  addr_hit;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic                  sw_grant;

   logic                  ram_we;
   logic                  load_hw;
   logic                  load_sw;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] sw_dout;

   // Write-data bits above the RAM width are never stored
   if (DATA_WIDTH < SW_DATA_WIDTH) begin : g_wdata_sink
      logic unused_wdata;
      assign unused_wdata = ^write_data[SW_DATA_WIDTH-1:DATA_WIDTH];
   end

   // Software address window decode
   always_comb begin
      addr_w   = 32'(address);
      addr_hit = (addr_w >= 32'(BASE_ADDR)) && (addr_w < 32'(BASE_ADDR + DEPTH));
      req_idx  = ADDR_WIDTH'(addr_w - 32'(BASE_ADDR));
   end

   // Software owns the port when hardware is idle or being pushed back
   assign sw_grant = (state == PEND) && ((!hw_ren && !hw_wen) || hw_busy);

   // RAM port multiplexer
   always_comb begin
      ram_we    = 1'b0;
      load_hw   = 1'b0;
      load_sw   = 1'b0;
      ram_addr  = hw_addr;
      ram_wdata = hw_wdata;
      if (sw_grant) begin
         ram_we    = sw_we;
         load_sw   = !sw_we;
         ram_addr  = sw_idx;
         ram_wdata = sw_wdata;
      end else if (!hw_busy) begin
         ram_we  = hw_wen;
         load_hw = hw_ren;
      end
   end

`ifdef RF_RAM_PARITY_EN
   logic hw_perr;
   logic sw_perr;
   logic sw_perr_q;

   // Hardware error pulses with the hw_rdata update, software error with completion
   assign parity_error = sw_perr_q | hw_perr;
`endif

   rf_ram_sp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .res     (res),
      .we      (ram_we),
      .load_hw (load_hw),
      .load_sw (load_sw),
      .addr    (ram_addr),
      .wdata   (ram_wdata),
`ifdef RF_RAM_PARITY_EN
      .hw_perr (hw_perr),
      .sw_perr (sw_perr),
`endif
      .hw_dout (hw_rdata),
      .sw_dout (sw_dout)
   );

   // Software access FSM with stall counter and registered completion outputs
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state           <= IDLE;
         stall_cnt       <= '0;
         sw_idx          <= '0;
         sw_we           <= 1'b0;
         sw_wdata        <= '0;
         read_data       <= '0;
         invalid_address <= 1'b0;
         access_complete <= 1'b0;
         hw_busy         <= 1'b0;
`ifdef RF_RAM_PARITY_EN
         sw_perr_q       <= 1'b0;
`endif
      end else begin
         access_complete <= 1'b0;
         invalid_address <= 1'b0;
         hw_busy         <= 1'b0;
`ifdef RF_RAM_PARITY_EN
         sw_perr_q       <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (read_en || write_en) begin
                  if ((read_en && write_en) || !addr_hit) begin
                     access_complete <= 1'b1;
                     invalid_address <= 1'b1;
                     read_data       <= '0;
                  end else begin
                     sw_idx   <= req_idx;
                     sw_we    <= write_en;
                     sw_wdata <= write_data[DATA_WIDTH-1:0];
                     state    <= PEND;
                  end
               end
            end
            PEND: begin
               if (sw_grant) begin
                  stall_cnt <= '0;
                  if (sw_we) begin
                     access_complete <= 1'b1;
                     state           <= DONE;
                  end else begin
                     state <= SW_RD;
                  end
               end else begin
                  stall_cnt <= stall_cnt + CW'(1);
                  if (stall_cnt == CW'(MAX_STALL - 1)) begin
                     hw_busy <= 1'b1;
                  end
               end
            end
            SW_RD: begin
               read_data       <= SW_DATA_WIDTH'(sw_dout);
               access_complete <= 1'b1;
`ifdef RF_RAM_PARITY_EN
               sw_perr_q       <= sw_perr;
`endif
               state           <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_ram_arbiter.sv
// Directed bench for rf_ram_arbiter (BASE_ADDR=32, DEPTH=32, MAX_STALL=4).
// Parity checks are included when RF_RAM_PARITY_EN is defined.
module tb_rf_ram_arbiter;
   import rf_ram_pkg::*;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 5;
   localparam int unsigned SAW = 10;

   logic          clk = 1'b0;
   logic          res;
   logic [SAW-4:0] address;
   logic          read_en;
   logic          write_en;
   logic [63:0]   write_data;
   logic [63:0]   read_data;
   logic          invalid_address;
   logic          access_complete;
   logic [AW-1:0] hw_addr;
   logic          hw_ren;
   logic [DW-1:0] hw_rdata;
   logic          hw_wen;
   logic [DW-1:0] hw_wdata;
   logic          hw_busy;
`ifdef RF_RAM_PARITY_EN
   logic          parity_error;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rf_ram_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .SW_ADDR_WIDTH (SAW),
      .BASE_ADDR     (32),
      .MAX_STALL     (4)
   ) dut (
      .clk             (clk),
      .res             (res),
      .address         (address),
      .read_en         (read_en),
      .write_en        (write_en),
      .write_data      (write_data),
      .read_data       (read_data),
      .invalid_address (invalid_address),
      .access_complete (access_complete),
      .hw_addr         (hw_addr),
      .hw_ren          (hw_ren),
      .hw_rdata        (hw_rdata),
      .hw_wen          (hw_wen),
      .hw_wdata        (hw_wdata),
`ifdef RF_RAM_PARITY_EN
      .parity_error    (parity_error),
`endif
      .hw_busy         (hw_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Issue one software request at a negedge and wait (bounded) for completion
   task automatic sw_access(input logic rd, input logic wr, input logic [SAW-4:0] a,
                            input logic [63:0] wd, output int lat, output logic inv,
                            output logic [63:0] rdat, output int busy_at, output int busy_n);
      address    = a;
      read_en    = rd;
      write_en   = wr;
      write_data = wd;
      lat = -1; inv = 1'b0; rdat = '0; busy_at = -1; busy_n = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         read_en  = 1'b0;
         write_en = 1'b0;
         if (hw_busy) begin
            busy_n++;
            if (busy_at < 0) busy_at = c;
         end
         if (access_complete) begin
            lat  = c;
            inv  = invalid_address;
            rdat = read_data;
            break;
         end
      end
      @(negedge clk);
   endtask

   initial begin : stim
      int          lat, busy_at, busy_n;
      logic        inv;
      logic [63:0] rdat;
      bit          seen;

      res = 1'b1; address = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
      hw_addr = '0; hw_ren = 1'b0; hw_wen = 1'b0; hw_wdata = '0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_read_data", read_data, 64'd0);
      chk("rst_invalid", 64'(invalid_address), 64'd0);
      chk("rst_complete", 64'(access_complete), 64'd0);
      chk("rst_hw_rdata", 64'(hw_rdata), 64'd0);
      chk("rst_hw_busy", 64'(hw_busy), 64'd0);
      res = 1'b0;
      @(negedge clk);

      // Fill the window with data = address
      for (int a = 32; a < 64; a++) begin
         sw_access(1'b0, 1'b1, (SAW-3)'(a), 64'(a), lat, inv, rdat, busy_at, busy_n);
         chk($sformatf("wr_lat[%0d]", a), 64'(lat), 64'd2);
         chk($sformatf("wr_inv[%0d]", a), 64'(inv), 64'd0);
      end

      sw_access(1'b1, 1'b0, 7'd40, '0, lat, inv, rdat, busy_at, busy_n);
      chk("rd40_lat", 64'(lat), 64'd3);
      chk("rd40_inv", 64'(inv), 64'd0);
      chk("rd40_data", rdat, 64'd40);

      // Back-to-back hardware reads
      for (int i = 0; i < 32; i++) begin
         hw_addr = AW'(i);
         hw_ren  = 1'b1;
         @(negedge clk);
         chk($sformatf("hw_rd[%0d]", i), 64'(hw_rdata), 64'(i + 32));
      end
      hw_ren = 1'b0;
      @(negedge clk);
      chk("hw_rdata_hold", 64'(hw_rdata), 64'd63);
      chk("read_data_kept", read_data, 64'd40);

      // Continuous hardware reads force the stall path
      hw_addr = '0;
      hw_ren  = 1'b1;
      sw_access(1'b1, 1'b0, 7'd33, '0, lat, inv, rdat, busy_at, busy_n);
      chk("stall_busy_at", 64'(busy_at), 64'd5);
      chk("stall_busy_n", 64'(busy_n), 64'd1);
      chk("stall_lat", 64'(lat), 64'd7);
      chk("stall_data", rdat, 64'd33);
      chk("stall_hw_rdata", 64'(hw_rdata), 64'd32);
      hw_ren = 1'b0;
      @(negedge clk);

      // Hardware write, then read-before-write on a combined access
      hw_addr = 5'd7; hw_wen = 1'b1; hw_wdata = 16'h1234;
      @(negedge clk);
      hw_wen = 1'b0;
      chk("hw_wr_no_rdata", 64'(hw_rdata), 64'd32);
      hw_addr = 5'd8; hw_wen = 1'b1; hw_ren = 1'b1; hw_wdata = 16'hA5A5;
      @(negedge clk);
      hw_wen = 1'b0; hw_ren = 1'b0;
      chk("hw_rbw_old", 64'(hw_rdata), 64'd40);
      sw_access(1'b1, 1'b0, 7'd39, '0, lat, inv, rdat, busy_at, busy_n);
      chk("rd39_data", rdat, 64'h1234);
      sw_access(1'b1, 1'b0, 7'd40, '0, lat, inv, rdat, busy_at, busy_n);
      chk("rd40_new", rdat, 64'hA5A5);

      // Out-of-window addresses, including both edges of the window
      sw_access(1'b1, 1'b0, 7'd3, '0, lat, inv, rdat, busy_at, busy_n);
      chk("miss3_lat", 64'(lat), 64'd1);
      chk("miss3_inv", 64'(inv), 64'd1);
      chk("miss3_data", rdat, 64'd0);
      sw_access(1'b1, 1'b0, 7'd96, '0, lat, inv, rdat, busy_at, busy_n);
      chk("miss96_lat", 64'(lat), 64'd1);
      chk("miss96_inv", 64'(inv), 64'd1);
      sw_access(1'b1, 1'b0, 7'd31, '0, lat, inv, rdat, busy_at, busy_n);
      chk("miss31_inv", 64'(inv), 64'd1);
      sw_access(1'b0, 1'b1, 7'd64, 64'hDEAD, lat, inv, rdat, busy_at, busy_n);
      chk("miss64_lat", 64'(lat), 64'd1);
      chk("miss64_inv", 64'(inv), 64'd1);
      sw_access(1'b1, 1'b0, 7'd63, '0, lat, inv, rdat, busy_at, busy_n);
      chk("hit63_inv", 64'(inv), 64'd0);
      chk("hit63_data", rdat, 64'd63);

      // Read and write together is rejected without touching the RAM
      sw_access(1'b1, 1'b1, 7'd41, 64'hFFFF, lat, inv, rdat, busy_at, busy_n);
      chk("illegal_lat", 64'(lat), 64'd1);
      chk("illegal_inv", 64'(inv), 64'd1);
      chk("illegal_data", rdat, 64'd0);
      sw_access(1'b1, 1'b0, 7'd41, '0, lat, inv, rdat, busy_at, busy_n);
      chk("rd41_data", rdat, 64'd41);

      // Reset while a request is stalled in PEND
      hw_addr = 5'd1; hw_ren = 1'b1;
      address = 7'd33; read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      chk("pend_state", 64'(dut.state), 64'(PEND));
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (access_complete || hw_busy) seen = 1'b1;
      end
      chk("rst_drop_complete", 64'(seen), 64'd0);
      chk("rst_state_idle", 64'(dut.state), 64'(IDLE));
      hw_ren = 1'b0;
      @(negedge clk);
      sw_access(1'b0, 1'b1, 7'd50, 64'd50, lat, inv, rdat, busy_at, busy_n);
      chk("wr50_lat", 64'(lat), 64'd2);
      sw_access(1'b1, 1'b0, 7'd50, '0, lat, inv, rdat, busy_at, busy_n);
      chk("rd50_lat", 64'(lat), 64'd3);
      chk("rd50_data", rdat, 64'd50);

`ifdef RF_RAM_PARITY_EN
      // Corrupt the stored parity of index 5 and read it from hardware
      dut.u_ram.mem[5][DW] = ~dut.u_ram.mem[5][DW];
      hw_addr = 5'd5; hw_ren = 1'b1;
      @(negedge clk);
      hw_ren = 1'b0;
      chk("par_hw_rdata", 64'(hw_rdata), 64'd37);
      chk("par_err_pulse", 64'(parity_error), 64'd1);
      @(negedge clk);
      chk("par_err_clear", 64'(parity_error), 64'd0);
      hw_addr = 5'd6; hw_ren = 1'b1;
      @(negedge clk);
      hw_ren = 1'b0;
      chk("par_ok_rdata", 64'(hw_rdata), 64'd38);
      chk("par_ok_err", 64'(parity_error), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
